// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one factorial engine among NREQ requesters.
// Operands n<=1 and n>MAXN are answered directly; others launch the engine and wait for done or timeout.
module fact_sched #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int DW   = 32,
  parameter int MAXN = 12,
  parameter int TMO  = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_req_n,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_rsp_valid,
  output logic [DW-1:0]     o_rsp_data,
  output logic [1:0]        o_rsp_code,
  output logic              o_eng_go,
  output logic [W-1:0]      o_eng_n,
  input  logic              i_eng_done,
  input  logic [DW-1:0]     i_eng_result,
  output logic              o_busy
);

  localparam int         PW         = $clog2(NREQ);
  localparam logic [7:0] TMO_C      = 8'(TMO);
  localparam logic [1:0] CODE_OK    = 2'd0;
  localparam logic [1:0] CODE_RANGE = 2'd1;
  localparam logic [1:0] CODE_TMO   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_LAUNCH,
    S_WAIT,
    S_RESPOND
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     w_next_ptr;
  logic [PW-1:0]     r_winner;
  logic [PW-1:0]     w_next_winner;
  logic [7:0]        r_cnt;
  logic [7:0]        w_next_cnt;

  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   w_next_ack;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [NREQ-1:0]   w_next_rsp_valid;
  logic [DW-1:0]     r_rsp_data;
  logic [DW-1:0]     w_next_rsp_data;
  logic [1:0]        r_rsp_code;
  logic [1:0]        w_next_rsp_code;
  logic              r_eng_go;
  logic              w_next_eng_go;
  logic [W-1:0]      r_eng_n;
  logic [W-1:0]      w_next_eng_n;
  logic              r_busy;

  logic              w_found;
  logic [PW-1:0]     w_win_idx;
  int                w_cand;
  logic [W-1:0]      w_gn;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // First active requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = r_ptr;
    w_cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = (int'(r_ptr) + k) % NREQ;
      if (!w_found && i_req[PW'(w_cand)]) begin
        w_found   = 1'b1;
        w_win_idx = PW'(w_cand);
      end
    end
  end

  assign w_gn = i_req_n[int'(r_winner)*W +: W];

  always_comb begin
    w_next_state     = r_state;
    w_next_ptr       = r_ptr;
    w_next_winner    = r_winner;
    w_next_cnt       = r_cnt;
    w_next_ack       = '0;
    w_next_rsp_valid = '0;
    w_next_rsp_data  = '0;
    w_next_rsp_code  = CODE_OK;
    w_next_eng_go    = 1'b0;
    w_next_eng_n     = r_eng_n;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next_winner = w_win_idx;
          w_next_ack    = onehot(w_win_idx);
          w_next_state  = S_GRANT;
        end
      end

      S_GRANT: begin
        w_next_ptr = (r_winner == PW'(NREQ-1)) ? '0 : r_winner + PW'(1);
        if (32'(w_gn) <= 32'd1) begin
          w_next_rsp_valid = onehot(r_winner);
          w_next_rsp_data  = DW'(1);
          w_next_rsp_code  = CODE_OK;
          w_next_state     = S_RESPOND;
        end else if (32'(w_gn) > 32'(MAXN)) begin
          w_next_rsp_valid = onehot(r_winner);
          w_next_rsp_data  = '0;
          w_next_rsp_code  = CODE_RANGE;
          w_next_state     = S_RESPOND;
        end else begin
          w_next_eng_go = 1'b1;
          w_next_eng_n  = w_gn;
          w_next_state  = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        w_next_cnt   = '0;
        w_next_state = S_WAIT;
      end

      // A done arriving in the same cycle as the timeout still counts as success.
      S_WAIT: begin
        if (i_eng_done) begin
          w_next_rsp_valid = onehot(r_winner);
          w_next_rsp_data  = i_eng_result;
          w_next_rsp_code  = CODE_OK;
          w_next_state     = S_RESPOND;
        end else if (r_cnt == TMO_C) begin
          w_next_rsp_valid = onehot(r_winner);
          w_next_rsp_data  = '0;
          w_next_rsp_code  = CODE_TMO;
          w_next_state     = S_RESPOND;
        end else begin
          w_next_cnt = r_cnt + 8'd1;
        end
      end

      S_RESPOND: begin
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_winner    <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_code  <= '0;
      r_eng_go    <= 1'b0;
      r_eng_n     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_ptr       <= w_next_ptr;
      r_winner    <= w_next_winner;
      r_cnt       <= w_next_cnt;
      r_ack       <= w_next_ack;
      r_rsp_valid <= w_next_rsp_valid;
      r_rsp_data  <= w_next_rsp_data;
      r_rsp_code  <= w_next_rsp_code;
      r_eng_go    <= w_next_eng_go;
      r_eng_n     <= w_next_eng_n;
      r_busy      <= (w_next_state != S_IDLE);
    end
  end

  assign o_ack       = r_ack;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_code  = r_rsp_code;
  assign o_eng_go    = r_eng_go;
  assign o_eng_n     = r_eng_n;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_fact_sched.sv
// Scoreboard bench for fact_sched: stimulus queues expected acks/launches/responses,
// independent monitor and engine-model processes pop and compare them.
module tb_fact_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;
  localparam int DW   = 32;
  localparam int MAXN = 12;
  localparam int TMO  = 255;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] reqN;
  logic [3:0]  ack;
  logic [3:0]  rspValid;
  logic [31:0] rspData;
  logic [1:0]  rspCode;
  logic        engGo;
  logic [3:0]  engN;
  logic        engDone;
  logic [31:0] engResult;
  logic        busy;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  code;
    int          kind;
  } rsp_t;

  rsp_t       rspQ[$];
  logic [3:0] ackQ[$];
  logic [3:0] goQ[$];

  int          checks     = 0;
  int          errors     = 0;
  int          cyc        = 0;
  int          lastAckCyc = 0;
  int          doneCyc    = 0;
  int          goCyc      = 0;
  int          goCount    = 0;
  int          expGo      = 0;
  int          engDelay   = 6;
  logic [31:0] engVal     = 0;
  logic        engBusy    = 1'b0;
  int          lat;

  fact_sched #(
    .NREQ(NREQ), .W(W), .DW(DW), .MAXN(MAXN), .TMO(TMO)
  ) dut (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_req       (req),
    .i_req_n     (reqN),
    .o_ack       (ack),
    .o_rsp_valid (rspValid),
    .o_rsp_data  (rspData),
    .o_rsp_code  (rspCode),
    .o_eng_go    (engGo),
    .o_eng_n     (engN),
    .i_eng_done  (engDone),
    .i_eng_result(engResult),
    .o_busy      (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish within 20000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_ack", 32'(ack), 0);
    checkOutput("rst_rsp_valid", 32'(rspValid), 0);
    checkOutput("rst_rsp_data", rspData, 0);
    checkOutput("rst_rsp_code", 32'(rspCode), 0);
    checkOutput("rst_eng_go", 32'(engGo), 0);
    checkOutput("rst_eng_n", 32'(engN), 0);
    checkOutput("rst_busy", 32'(busy), 0);
  endtask

  // kind: 0 = answered one cycle after ack, 1 = one cycle after engine done, 2 = timeout after go
  task automatic expectJob(input logic [3:0] a, input int goN, input logic [31:0] d, input logic [1:0] c, input int k);
    ackQ.push_back(a);
    if (goN >= 0) begin
      goQ.push_back(4'(goN));
      expGo++;
    end
    rspQ.push_back('{valid: a, data: d, code: c, kind: k});
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] n);
    @(negedge clock);
    req  = r;
    reqN = n;
  endtask

  task automatic waitAcks(input int nAcks, output int firstLat);
    int seen;
    seen     = 0;
    firstLat = -1;
    for (int i = 1; i <= 100 && seen < nAcks; i++) begin
      @(negedge clock);
      if (ack != 4'b0) begin
        seen++;
        if (firstLat < 0) firstLat = i;
      end
    end
    req = 4'b0;
    checkOutput("ack_count", 32'(seen), 32'(nAcks));
  endtask

  task automatic waitIdle(input int maxCyc);
    logic idleSeen;
    idleSeen = 1'b0;
    for (int i = 0; i < maxCyc && !idleSeen; i++) begin
      @(negedge clock);
      if (!busy && !engBusy && !engDone && rspQ.size() == 0) idleSeen = 1'b1;
    end
    checkOutput("idle_reached", 32'(idleSeen), 1);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Engine model: done pulse engDelay cycles after go, aborted by reset.
  initial begin : engine
    logic aborted;
    engDone   = 1'b0;
    engResult = '0;
    forever begin
      @(negedge clock);
      if (!reset && engGo) begin
        goCyc = cyc;
        goCount++;
        if (goQ.size() == 0) checkOutput("go_unexpected", 32'(engGo), 0);
        else checkOutput("eng_n", 32'(engN), 32'(goQ.pop_front()));
        engBusy = 1'b1;
        aborted = 1'b0;
        for (int k = 0; k < engDelay && !aborted; k++) begin
          @(negedge clock);
          if (reset) aborted = 1'b1;
        end
        if (!aborted) begin
          engDone   = 1'b1;
          engResult = engVal;
          doneCyc   = cyc;
          @(negedge clock);
          engDone   = 1'b0;
          engResult = '0;
        end
        engBusy = 1'b0;
      end
    end
  end

  initial begin : monitor
    rsp_t e;
    int   expCyc;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (ack != 4'b0) begin
          lastAckCyc = cyc;
          if (ackQ.size() == 0) checkOutput("ack_unexpected", 32'(ack), 0);
          else checkOutput("ack", 32'(ack), 32'(ackQ.pop_front()));
        end
        if (rspValid != 4'b0) begin
          if (rspQ.size() == 0) begin
            checkOutput("rsp_unexpected", 32'(rspValid), 0);
          end else begin
            e = rspQ.pop_front();
            checkOutput("rsp_valid", 32'(rspValid), 32'(e.valid));
            checkOutput("rsp_data", rspData, e.data);
            checkOutput("rsp_code", 32'(rspCode), 32'(e.code));
            case (e.kind)
              0:       expCyc = lastAckCyc + 1;
              1:       expCyc = doneCyc + 1;
              default: expCyc = goCyc + TMO + 2;
            endcase
            checkOutput("rsp_cycle", 32'(cyc), 32'(expCyc));
          end
        end else begin
          checkOutput("idle_rsp_data", rspData, 0);
          checkOutput("idle_rsp_code", 32'(rspCode), 0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = 4'b0;
    reqN  = 16'h0;
    repeat (3) @(negedge clock);
    checkResetOutputs();
    reset = 1'b0;

    $display("[TB] single engine job n=5");
    engDelay = 6;
    engVal   = 120;
    expectJob(4'b0001, 5, 120, 2'd0, 1);
    applyStimulus(4'b0001, 16'h0005);
    waitAcks(1, lat);
    checkOutput("t1_ack_latency", 32'(lat), 1);
    waitIdle(100);
    checkOutput("t1_go_count", 32'(goCount), 1);

    $display("[TB] round robin with all requesters active");
    doReset();
    engVal = 6;
    for (int i = 0; i < 5; i++) expectJob(4'b0001 << (i % 4), 3, 6, 2'd0, 1);
    applyStimulus(4'b1111, 16'h3333);
    waitAcks(5, lat);
    waitIdle(100);

    $display("[TB] trivial operands on requester 2");
    expectJob(4'b0100, -1, 1, 2'd0, 0);
    applyStimulus(4'b0100, 16'h0000);
    waitAcks(1, lat);
    checkOutput("t3_ack_latency", 32'(lat), 1);
    waitIdle(50);
    expectJob(4'b0100, -1, 1, 2'd0, 0);
    applyStimulus(4'b0100, 16'h0100);
    waitAcks(1, lat);
    waitIdle(50);
    checkOutput("t3_go_count", 32'(goCount), 6);

    $display("[TB] range boundaries");
    expectJob(4'b1000, -1, 0, 2'd1, 0);
    applyStimulus(4'b1000, 16'hD000);
    waitAcks(1, lat);
    waitIdle(50);
    expectJob(4'b0010, -1, 0, 2'd1, 0);
    applyStimulus(4'b0010, 16'h00F0);
    waitAcks(1, lat);
    waitIdle(50);
    engVal = 479001600;
    expectJob(4'b0001, 12, 479001600, 2'd0, 1);
    applyStimulus(4'b0001, 16'h000C);
    waitAcks(1, lat);
    waitIdle(100);
    engVal = 2;
    expectJob(4'b0100, 2, 2, 2'd0, 1);
    applyStimulus(4'b0100, 16'h0200);
    waitAcks(1, lat);
    waitIdle(100);
    checkOutput("t4_go_count", 32'(goCount), 8);

    $display("[TB] timeout with late done");
    engDelay = 262;
    engVal   = 32'hDEAD;
    expectJob(4'b0001, 4, 0, 2'd2, 2);
    applyStimulus(4'b0001, 16'h0004);
    waitAcks(1, lat);
    waitIdle(400);

    $display("[TB] done on the last wait cycle");
    engDelay = 256;
    engVal   = 24;
    expectJob(4'b0010, 4, 24, 2'd0, 1);
    applyStimulus(4'b0010, 16'h0040);
    waitAcks(1, lat);
    waitIdle(400);

    $display("[TB] reset while waiting on the engine");
    engDelay = 20;
    engVal   = 120;
    ackQ.push_back(4'b0001);
    goQ.push_back(4'd5);
    expGo++;
    applyStimulus(4'b0001, 16'h0005);
    waitAcks(1, lat);
    repeat (3) @(negedge clock);
    checkOutput("t7_busy_before_reset", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkResetOutputs();
    reset = 1'b0;
    expectJob(4'b0010, -1, 1, 2'd0, 0);
    expectJob(4'b1000, -1, 1, 2'd0, 0);
    applyStimulus(4'b1010, 16'h1000);
    waitAcks(2, lat);
    checkOutput("t7_first_ack_latency", 32'(lat), 1);
    waitIdle(50);

    checkOutput("ack_queue_empty", 32'(ackQ.size()), 0);
    checkOutput("rsp_queue_empty", 32'(rspQ.size()), 0);
    checkOutput("go_queue_empty", 32'(goQ.size()), 0);
    checkOutput("go_total", 32'(goCount), 32'(expGo));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
